// File: rtl/countdown_timer_bcd.sv
// countdown_timer_bcd
//   mm:ss match/session timer feeding a 4-digit 7-segment path with BCD digits
//   and a sign digit. It counts down from a preset at a prescaled tick rate.
//   After 00:00 it either counts up in overtime, showing a minus sign and
//   saturating at 99:59, or it halts.
// Ports
//   input_clk               clock
//   reset                   synchronous active-high reset, overrides all inputs
//   start                   IDLE -> COUNTDOWN
//   hold                    level pause of prescaler and digits while counting
//   stop                    freeze into HALTED while counting
//   load, load_min/load_sec BCD start value load (IDLE/HALTED only)
//   out_H_min..out_L_sec    BCD digits, zero-extended to 5 bits
//   out_sign                BLANK_CODE or MINUS_CODE
//   running                 counting and not held (registered)
//   expired                 sticky 00:00-reached flag, cleared by reset/load
//   expired_pulse           one cycle on the countdown expiry step
//   load_err                one cycle when a load value is rejected
module countdown_timer_bcd #(
  parameter int unsigned TICK_DIV    = 50_000_000,
  parameter int unsigned PRESET_MIN  = 20,
  parameter int unsigned PRESET_SEC  = 0,
  parameter bit          OVERTIME_EN = 1'b1,
  parameter logic [4:0]  BLANK_CODE  = 5'b11111,
  parameter logic [4:0]  MINUS_CODE  = 5'b10001
) (
  input  logic       input_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       hold,
  input  logic       stop,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  output logic [4:0] out_H_min,
  output logic [4:0] out_L_min,
  output logic [4:0] out_H_sec,
  output logic [4:0] out_L_sec,
  output logic [4:0] out_sign,
  output logic       running,
  output logic       expired,
  output logic       expired_pulse,
  output logic       load_err
);

  localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] P_HM = 4'(PRESET_MIN / 10);
  localparam logic [3:0] P_LM = 4'(PRESET_MIN % 10);
  localparam logic [3:0] P_HS = 4'(PRESET_SEC / 10);
  localparam logic [3:0] P_LS = 4'(PRESET_SEC % 10);

  typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_OVERTIME, S_HALTED} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    hm_q, hm_d, lm_q, lm_d, hs_q, hs_d, ls_q, ls_d;
  logic [4:0]    sign_q, sign_d;
  logic          running_q, running_d;
  logic          expired_q, expired_d;
  logic          pulse_q, pulse_d;
  logic          err_q, err_d;
  logic          tick, load_ok, at_zero, at_max;

  assign load_ok = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                   (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
  assign at_zero = (hm_q == 4'd0) && (lm_q == 4'd0) && (hs_q == 4'd0) && (ls_q == 4'd0);
  assign at_max  = (hm_q == 4'd9) && (lm_q == 4'd9) && (hs_q == 4'd5) && (ls_q == 4'd9);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    hm_d      = hm_q;
    lm_d      = lm_q;
    hs_d      = hs_q;
    ls_d      = ls_q;
    sign_d    = sign_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;
    err_d     = 1'b0;
    tick      = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALTED: begin
        // load takes precedence over start; start only acts from IDLE
        if (load) begin
          if (load_ok) begin
            {hm_d, lm_d} = load_min;
            {hs_d, ls_d} = load_sec;
            state_d      = S_IDLE;
            sign_d       = BLANK_CODE;
            expired_d    = 1'b0;
            presc_d      = '0;
          end else begin
            err_d = 1'b1;
          end
        end else if (start && (state_q == S_IDLE)) begin
          state_d = S_COUNTDOWN;
          presc_d = '0;
        end
      end
      S_COUNTDOWN, S_OVERTIME: begin
        if (stop) begin
          state_d = S_HALTED;
        end else if (!hold) begin
          tick    = (presc_q == PRE_MAX);
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (tick && (state_q == S_COUNTDOWN)) begin
            if (at_zero) begin
              expired_d = 1'b1;
              pulse_d   = 1'b1;
              sign_d    = MINUS_CODE;
              state_d   = OVERTIME_EN ? S_OVERTIME : S_HALTED;
            end else if (ls_q != 4'd0) begin
              ls_d = ls_q - 4'd1;
            end else begin
              ls_d = 4'd9;
              if (hs_q != 4'd0) begin
                hs_d = hs_q - 4'd1;
              end else begin
                hs_d = 4'd5;
                if (lm_q != 4'd0) begin
                  lm_d = lm_q - 4'd1;
                end else begin
                  lm_d = 4'd9;
                  hm_d = hm_q - 4'd1;
                end
              end
            end
          end else if (tick && !at_max) begin
            if (ls_q != 4'd9) begin
              ls_d = ls_q + 4'd1;
            end else begin
              ls_d = 4'd0;
              if (hs_q != 4'd5) begin
                hs_d = hs_q + 4'd1;
              end else begin
                hs_d = 4'd0;
                if (lm_q != 4'd9) begin
                  lm_d = lm_q + 4'd1;
                end else begin
                  lm_d = 4'd0;
                  hm_d = hm_q + 4'd1;
                end
              end
            end
          end
        end
      end
      default: ;
    endcase

    running_d = ((state_d == S_COUNTDOWN) || (state_d == S_OVERTIME)) && !hold;
  end

  always_ff @(posedge input_clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      hm_q      <= P_HM;
      lm_q      <= P_LM;
      hs_q      <= P_HS;
      ls_q      <= P_LS;
      sign_q    <= BLANK_CODE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      hm_q      <= hm_d;
      lm_q      <= lm_d;
      hs_q      <= hs_d;
      ls_q      <= ls_d;
      sign_q    <= sign_d;
      running_q <= running_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      err_q     <= err_d;
    end
  end

  assign out_H_min     = {1'b0, hm_q};
  assign out_L_min     = {1'b0, lm_q};
  assign out_H_sec     = {1'b0, hs_q};
  assign out_L_sec     = {1'b0, ls_q};
  assign out_sign      = sign_q;
  assign running       = running_q;
  assign expired       = expired_q;
  assign expired_pulse = pulse_q;
  assign load_err      = err_q;

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Bench for countdown_timer_bcd: two instances share one stimulus stream.
//   dut 0: TICK_DIV=1, preset 00:03, overtime enabled
//   dut 1: TICK_DIV=4, preset 20:00, overtime disabled
// A time-in-seconds reference model per instance predicts every output.
module tb_countdown_timer_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, hold, stop, load;
  logic [7:0] load_min, load_sec;

  logic [1:0][4:0] o_hm, o_lm, o_hs, o_ls, o_sign;
  logic [1:0]      o_run, o_exp, o_pulse, o_err;

  countdown_timer_bcd #(.TICK_DIV(1), .PRESET_MIN(0), .PRESET_SEC(3), .OVERTIME_EN(1'b1)) dut0 (
    .input_clk(clk), .reset(reset), .start(start), .hold(hold), .stop(stop), .load(load),
    .load_min(load_min), .load_sec(load_sec),
    .out_H_min(o_hm[0]), .out_L_min(o_lm[0]), .out_H_sec(o_hs[0]), .out_L_sec(o_ls[0]),
    .out_sign(o_sign[0]), .running(o_run[0]), .expired(o_exp[0]),
    .expired_pulse(o_pulse[0]), .load_err(o_err[0]));

  countdown_timer_bcd #(.TICK_DIV(4), .PRESET_MIN(20), .PRESET_SEC(0), .OVERTIME_EN(1'b0)) dut1 (
    .input_clk(clk), .reset(reset), .start(start), .hold(hold), .stop(stop), .load(load),
    .load_min(load_min), .load_sec(load_sec),
    .out_H_min(o_hm[1]), .out_L_min(o_lm[1]), .out_H_sec(o_hs[1]), .out_L_sec(o_ls[1]),
    .out_sign(o_sign[1]), .running(o_run[1]), .expired(o_exp[1]),
    .expired_pulse(o_pulse[1]), .load_err(o_err[1]));

  // Reference model: time held as plain seconds, modes as small integers.
  localparam int M_IDLE = 0, M_DOWN = 1, M_OVER = 2, M_HALT = 3;
  int m_td[2], m_preset[2];
  bit m_oten[2];
  int m_mode[2], m_secs[2], m_cnt[2];
  bit m_minus[2], m_run[2], m_exp[2], m_pulse[2], m_err[2];

  int unsigned n_vec = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    bit ok;
    int ld;
    m_pulse[k] = 1'b0;
    m_err[k]   = 1'b0;
    if (reset) begin
      m_mode[k] = M_IDLE; m_secs[k] = m_preset[k]; m_cnt[k] = 0;
      m_minus[k] = 1'b0; m_run[k] = 1'b0; m_exp[k] = 1'b0;
      return;
    end
    ok = (load_min[7:4] <= 9) && (load_min[3:0] <= 9) && (load_sec[7:4] <= 5) && (load_sec[3:0] <= 9);
    ld = (int'(load_min[7:4]) * 10 + int'(load_min[3:0])) * 60 + int'(load_sec[7:4]) * 10 + int'(load_sec[3:0]);
    if (m_mode[k] == M_IDLE || m_mode[k] == M_HALT) begin
      if (load) begin
        if (ok) begin
          m_secs[k] = ld; m_mode[k] = M_IDLE; m_minus[k] = 1'b0; m_exp[k] = 1'b0; m_cnt[k] = 0;
        end else begin
          m_err[k] = 1'b1;
        end
      end else if (start && m_mode[k] == M_IDLE) begin
        m_mode[k] = M_DOWN; m_cnt[k] = 0;
      end
    end else if (stop) begin
      m_mode[k] = M_HALT;
    end else if (!hold) begin
      m_cnt[k]++;
      if (m_cnt[k] == m_td[k]) begin
        m_cnt[k] = 0;
        if (m_mode[k] == M_DOWN) begin
          if (m_secs[k] == 0) begin
            m_exp[k] = 1'b1; m_pulse[k] = 1'b1; m_minus[k] = 1'b1;
            m_mode[k] = m_oten[k] ? M_OVER : M_HALT;
          end else begin
            m_secs[k]--;
          end
        end else if (m_secs[k] < 99 * 60 + 59) begin
          m_secs[k]++;
        end
      end
    end
    m_run[k] = (m_mode[k] == M_DOWN || m_mode[k] == M_OVER) && !hold;
  endtask

  task automatic compare(input int k);
    int mm, ss;
    logic [19:0] want;
    mm = m_secs[k] / 60;
    ss = m_secs[k] % 60;
    want = {5'(mm / 10), 5'(mm % 10), 5'(ss / 10), 5'(ss % 10)};
    check($sformatf("digits%0d", k), 32'({o_hm[k], o_lm[k], o_hs[k], o_ls[k]}), 32'(want));
    check($sformatf("sign%0d", k), 32'(o_sign[k]), m_minus[k] ? 32'h11 : 32'h1f);
    check($sformatf("running%0d", k), 32'(o_run[k]), 32'(m_run[k]));
    check($sformatf("expired%0d", k), 32'(o_exp[k]), 32'(m_exp[k]));
    check($sformatf("expired_pulse%0d", k), 32'(o_pulse[k]), 32'(m_pulse[k]));
    check($sformatf("load_err%0d", k), 32'(o_err[k]), 32'(m_err[k]));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later,
  // returns at the falling edge so the caller can drive the next inputs.
  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    for (int k = 0; k < 2; k++) compare(k);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic idle_in();
    reset = 1'b0; start = 1'b0; hold = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] mn, input logic [7:0] sc);
    load = 1'b1; load_min = mn; load_sec = sc;
    cycle();
    load = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  initial begin
    m_td     = '{1, 4};
    m_preset = '{3, 20 * 60};
    m_oten   = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_secs[k] = m_preset[k]; m_cnt[k] = 0;
      m_minus[k] = 0; m_run[k] = 0; m_exp[k] = 0; m_pulse[k] = 0; m_err[k] = 0;
    end
    idle_in();
    load_min = 8'h00; load_sec = 8'h00;

    reset = 1'b1; run(2); reset = 1'b0;
    run(2);

    // countdown to expiry and into overtime
    pulse_start();
    run(8);

    // hold mid-interval, then release
    hold = 1'b1; run(10); hold = 1'b0;
    run(12);

    // stop, ignored start, rejected loads, accepted load
    pulse_stop();
    pulse_start();
    do_load(8'h12, 8'h60);
    do_load(8'h1A, 8'h00);
    do_load(8'h45, 8'h30);
    run(2);

    // borrow chains
    do_load(8'h10, 8'h00); pulse_start(); run(6); pulse_stop();
    do_load(8'h01, 8'h00); pulse_start(); run(6); pulse_stop();
    do_load(8'h20, 8'h00); pulse_start(); run(6); pulse_stop();

    // stop coinciding with a tick
    do_load(8'h05, 8'h08); pulse_start(); run(1); pulse_stop();
    pulse_start();
    run(2);

    // short run: dut1 halts at 00:00, dut0 enters overtime
    do_load(8'h00, 8'h02); pulse_start(); run(16);
    pulse_start();
    do_load(8'h00, 8'h05);
    run(2);

    // start and load together in IDLE; hold while idle
    pulse_stop();
    do_load(8'h00, 8'h00);
    start = 1'b1; load = 1'b1; load_min = 8'h00; load_sec = 8'h09; cycle();
    start = 1'b0; load = 1'b0;
    hold = 1'b1; run(3); hold = 1'b0;
    pulse_start(); run(3);

    // long overtime run to saturation, then reset mid-run
    reset = 1'b1; run(1); reset = 1'b0;
    do_load(8'h00, 8'h03);
    pulse_start();
    run(3000);
    do_load(8'h11, 8'h11);
    run(3020);
    reset = 1'b1; run(1); reset = 1'b0;
    run(2);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 9) == 0);
      load  = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 3) != 0) begin
        load_min = ($urandom_range(0, 1) == 0) ? 8'h00
                   : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        load_sec = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        if ($urandom_range(0, 1) == 0) load_sec = {4'd0, 4'($urandom_range(0, 9))};
      end else begin
        load_min = 8'($urandom);
        load_sec = 8'($urandom);
      end
      cycle();
    end
    idle_in();
    run(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
